// File: rtl/sqrt_pkg.sv
// Shared types and defaults for the odd-increment square-root unit.
// Used by the controller, the wrapper and the datapath bench.
package sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        TEST,
        OUTLD,
        DONE,
        ERR
    } sqrt_state_t;

    localparam int SQRT_MAX_ITER = 16;
    localparam int SQRT_CNT_W    = 5;

endpackage

// File: rtl/sqrt_ctrl.sv
// Sequencer for the odd-increment square-root datapath.
// Iterates sq += del, del += 2 while sq <= a, with a runaway guard.
module sqrt_ctrl
    import sqrt_pkg::*;
#(
    parameter int MAX_ITER = SQRT_MAX_ITER,
    parameter int CNT_W    = SQRT_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             ack,
    input  logic             lteflg,
    output logic             dp_clr,
    output logic             ald,
    output logic             sqld,
    output logic             dld,
    output logic             outld,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ITER);

    sqrt_state_t      state_q;
    sqrt_state_t      state_d;
    logic [CNT_W-1:0] iter_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // INIT restarts the count; it only advances on an update cycle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            iter_q <= '0;
        end else if (state_q == INIT) begin
            iter_q <= '0;
        end else if (sqld) begin
            iter_q <= iter_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        dp_clr  = 1'b0;
        ald     = 1'b0;
        sqld    = 1'b0;
        dld     = 1'b0;
        outld   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                dp_clr  = 1'b1;
                busy    = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                ald     = 1'b1;
                busy    = 1'b1;
                state_d = TEST;
            end
            TEST: begin
                busy = 1'b1;
                if (!lteflg) begin
                    state_d = OUTLD;
                end else if (iter_q < MAX_C) begin
                    sqld = 1'b1;
                    dld  = 1'b1;
                end else begin
                    state_d = ERR;
                end
            end
            OUTLD: begin
                outld   = 1'b1;
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (ack) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                err = 1'b1;
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign iter = iter_q;

endmodule

// File: doc/sqrt_ctrl.md
# sqrt_ctrl

Sequencing controller for the 8-bit odd-increment square-root datapath (`a`, `sq`, `del` and `out` registers driven by `clr`/`ald`/`sqld`/`dld`/`outld`, returning `lteflg`).
- Accepts a start request and reinitialises the datapath.
- Loads the operand, then iterates `sq += del; del += 2` while `lteflg` is high.
- Loads the root, then holds a done/ack handshake toward the requester.
- Includes an iteration guard that flags a runaway loop.

## Interface
Parameters:
- MAX_ITER, 16, maximum update iterations before error (legal roots 0..15 need ≤15)
- CNT_W, 5, iteration counter width; must hold MAX_ITER

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- ack  in  1  requester acknowledge; sampled only in DONE/ERR
- lteflg  in  1  datapath compare `sq <= a` (combinational)
- dp_clr  out  1  one-cycle active-high pulse: reinitialise datapath (`sq`=1, `del`=3)
- ald  out  1  load operand register from switches
- sqld  out  1  load `sq` register
- dld  out  1  load `del` register
- outld  out  1  load root output register
- busy  out  1  high in INIT, LOAD, TEST, OUTLD
- done  out  1  root valid; high in DONE
- err  out  1  iteration overflow; high in ERR
- iter  out  CNT_W  number of completed update iterations for current/last operation

## Operation
- States: IDLE, INIT, LOAD, TEST, OUTLD, DONE, ERR. All control outputs are Moore-decoded, except `sqld`/`dld` in TEST.
- IDLE: all strobes 0. `start`=1 → INIT.
- INIT: `dp_clr`=1; `iter` cleared → LOAD.
- LOAD: `ald`=1 → TEST.
- TEST:
  - `lteflg`=1 and `iter`<MAX_ITER: `sqld`=`dld`=1 in the same cycle, `iter`+1, stay in TEST.
  - `lteflg`=0: no strobes → OUTLD.
  - `lteflg`=1 and `iter`==MAX_ITER: no strobes → ERR.
- OUTLD: `outld`=1 → DONE.
- DONE: `done`=1, `iter` frozen. `ack`=1 → IDLE.
- ERR: `err`=1. `ack`=1 → IDLE.
- Strobe exclusivity:
  - `sqld` and `dld` are always asserted together.
  - `ald`, `dp_clr` and `outld` are never coincident with each other or with `sqld`/`dld`.
- `start` outside IDLE is ignored; it is not queued.
- `ack` outside DONE/ERR is ignored.
- `start` and `ack` high together in DONE: `ack` wins → IDLE. The `start` is ignored and must be reasserted.
- Counter arithmetic: unsigned CNT_W bits, no wrap. Increments only on an update cycle.
- Root result equals `iter` for a correct datapath. The verification bench compares the datapath root against `iter`.

## Timing
- Reset (`clr`=0, asynchronous): state IDLE. `dp_clr`, `ald`, `sqld`, `dld`, `outld`, `busy`, `done`, `err` = 0; `iter` = 0. Applies immediately, including mid-operation.
- After reset, the datapath is not touched until the next INIT. A fresh operation always re-clears it.
- Latency for operand with root r (0..15):
  - Edge 0 samples `start`.
  - `done` rises at edge r+4 and holds until `ack`.
- Sequence for root r:
  - INIT occupies cycle 1.
  - LOAD occupies cycle 2.
  - TEST occupies r+1 cycles (r update cycles plus one exit cycle).
  - OUTLD follows for one cycle.
- `lteflg` is evaluated in the cycle after the `sq` update edge. `sqld`/`dld` depend combinationally on `lteflg` only in TEST.
- Back-to-back operation:
  - `ack` sampled at edge k → IDLE.
  - `start` can be sampled at edge k+1, giving a minimum 1 idle cycle.

## Structure
- Shared package `sqrt_pkg`:
  - state enum `sqrt_state_t` (7 states, 3-bit)
  - default constants `SQRT_MAX_ITER`=16 and `SQRT_CNT_W`=5
  - shared by the datapath testbench and the top-level wrapper.
- Single module. No sub-module; the iteration counter is inline.
- Top level `sqrt_top` instantiates `sqrt_ctrl` with the datapath. It maps `dp_clr` OR'ed with the inverted `clr` onto the datapath's clear.

## Test plan
- Operand 0, `start` pulse → no update cycles; `done` at edge 4; `iter`=0; root 0.
- Operand 255 → 15 update cycles; `done` at edge 19; `iter`=15; root 15. Operand 16 → `iter`=4; `done` at edge 8.
- Force `lteflg`=1 permanently → 16 update cycles, then ERR with `err`=1 and `done`=0. `ack` → IDLE with all outputs 0.
- `clr` asserted during TEST (after 3 updates) → all outputs 0 immediately. A following `start` with operand 9 → root 3; `dp_clr` pulse observed.
- `start` held high throughout an operation → exactly one operation, with no restart in TEST/DONE.
- Hold `ack` low in DONE for 10 cycles → `done` held. Then `start`+`ack` together → IDLE, no new operation.
- Strobe checks, every cycle:
  - no coincidence of `ald`/`dp_clr`/`outld`/(`sqld`|`dld`)
  - `sqld`==`dld` always
